// File: rtl/sram_pkg.sv
// Shared voltage levels and controller state encoding for the SRAM array slice.
package sram_pkg;

  localparam real VDD = 1.5;
  localparam real VSS = 0.0;
  localparam real VTH = 0.8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    WL_ON,
    SENSE
  } ctrl_state_t;

  // Logic-level view of an analog node
  function automatic logic is_high(input real v);
    return (v >= VTH);
  endfunction

endpackage

// File: rtl/sram_sense_amp.sv
// Single-column sense amplifier: resolves a bitline pair into a data bit and an
// ambiguity flag (both rails low = never written, both high = contention).
module sram_sense_amp
  import sram_pkg::*;
(
  input  real  bl,
  input  real  blb,
  output logic bit_o,
  output logic err
);

  // Threshold compare of the differential pair
  always_comb begin
    bit_o = is_high(bl) && !is_high(blb);
    err   = (is_high(bl) == is_high(blb));
  end

endmodule

// File: rtl/sram_ctrl.sv
// Request sequencer for an unclocked ROWS x DATA_W array of real-valued cells.
// Latches one request, sequences bitline setup, wordline pulse and sensing,
// then returns a single-cycle response.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned WL_CYC    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output real               row_wr [2**ADDR_W],
  output real               bl_wr  [DATA_W],
  output real               blb_wr [DATA_W],
  input  real               bl_rd  [2**ADDR_W][DATA_W],
  input  real               blb_rd [2**ADDR_W][DATA_W]
);

  localparam int unsigned ROWS    = 2**ADDR_W;
  localparam int unsigned CNT_MAX = (SETUP_CYC > WL_CYC) ? SETUP_CYC : WL_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  ctrl_state_t       state_q,     state_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic              we_q,        we_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [DATA_W-1:0] wdata_q,     wdata_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q,   rsp_err_d;
  logic [ROWS-1:0]   row_on_q,    row_on_d;
  logic              drive_q,     drive_d;

  logic [DATA_W-1:0] sns_bit;
  logic [DATA_W-1:0] sns_err;

  // One sense amp per column, fed from the latched row
  for (genvar c = 0; c < DATA_W; c++) begin : g_sa
    sram_sense_amp u_sa (
      .bl    (bl_rd[addr_q][c]),
      .blb   (blb_rd[addr_q][c]),
      .bit_o (sns_bit[c]),
      .err   (sns_err[c])
    );
  end

  // Next-state, request latch, response and drive-enable computation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          we_d        = req_we;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          req_ready_d = 1'b0;
          cnt_d       = CNT_W'(SETUP_CYC - 1);
          state_d     = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_W'(WL_CYC - 1);
          state_d = WL_ON;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WL_ON: begin
        if (cnt_q == '0) begin
          state_d = SENSE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SENSE: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = we_q ? '0 : sns_bit;
        rsp_err_d   = !we_q && (|sns_err);
      end
      default: state_d = IDLE;
    endcase

    // Enables follow the next state so the analog drives change on the same
    // edge as the state: the wordline drops entering SENSE while bitlines stay
    // driven, and bitlines release only when returning to IDLE.
    row_on_d = '0;
    if (state_d == WL_ON) begin
      row_on_d[addr_d] = 1'b1;
    end
    drive_d = we_d && (state_d != IDLE);
  end

  // Controller state, latched request and registered drive enables
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      row_on_q    <= '0;
      drive_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      row_on_q    <= row_on_d;
      drive_q     <= drive_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Wordline voltages from the registered one-hot row enable
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign row_wr[r] = row_on_q[r] ? VDD : VSS;
  end

  // Differential bitline drive; both rails stay at VSS when not writing
  for (genvar c = 0; c < DATA_W; c++) begin : g_bl
    assign bl_wr[c]  = (drive_q &&  wdata_q[c]) ? VDD : VSS;
    assign blb_wr[c] = (drive_q && !wdata_q[c]) ? VDD : VSS;
  end

endmodule
